// File: rtl/flag_select_ctrl_if.sv
// Button/config/index bundle between the pin front-end and the flag lookup stage.
// master drives buttons, count and frame timing; slave (the controller) returns the index.
interface flag_select_ctrl_if;
    logic       btn_reset;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_load;
    logic [7:0] load_value;
    logic [7:0] count;
    logic       frame_start;
    logic       auto_en;
    logic [7:0] index;
    logic       index_changed;
    logic       busy;

    modport master (
        output btn_reset, btn_next, btn_prev, btn_load,
        output load_value, count, frame_start, auto_en,
        input  index, index_changed, busy
    );

    modport slave (
        input  btn_reset, btn_next, btn_prev, btn_load,
        input  load_value, count, frame_start, auto_en,
        output index, index_changed, busy
    );
endinterface

// File: rtl/flag_select_ctrl.sv
// Debounced flag-select controller: pending index updated by button presses, committed at frame start.
// Define AUTO_CYCLE_EN to add the automatic advance every AUTO_FRAMES frames while auto_en is high.
//
// state   | meaning
// IDLE    | accepting press pulses, clamping pend to the current flag count
// REDUCE  | reducing a loaded value modulo the flag count by repeated subtraction
module flag_select_ctrl #(
    parameter int DB_WIDTH    = 16,
    parameter int DB_LIMIT    = 65535,
    parameter int AUTO_FRAMES = 120
) (
    input logic               clk,
    input logic               rst_n,
    flag_select_ctrl_if.slave bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REDUCE = 1'b1;
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_LIMIT - 1);

    // bit order everywhere: 0 reset, 1 next, 2 prev, 3 load
    logic [3:0]          raw_btn;
    logic [3:0]          sync1_q, sync1_d;
    logic [3:0]          sync2_q, sync2_d;
    logic [3:0]          db_state_q, db_state_d;
    logic [DB_WIDTH-1:0] db_cnt_q [4];
    logic [DB_WIDTH-1:0] db_cnt_d [4];
    logic [3:0]          press;

    logic [0:0] state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] work_q, work_d;
    logic [7:0] index_q, index_d;
    logic       changed_q, changed_d;
    logic       busy_q, busy_d;

    logic [7:0] ceff;
    logic [8:0] pend_inc;
    logic [7:0] pend_nxt;
    logic [7:0] pend_prv;
    logic       auto_pulse;

    assign raw_btn = {bus.btn_load, bus.btn_prev, bus.btn_next, bus.btn_reset};

    always_comb begin
        sync1_d    = raw_btn;
        sync2_d    = sync1_q;
        db_state_d = db_state_q;
        press      = '0;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_state_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_state_d[i] = sync2_q[i];
                    press[i]      = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ceff     = (bus.count == 8'd0) ? 8'd1 : bus.count;
        pend_inc = {1'b0, pend_q} + 9'd1;
        pend_nxt = (pend_inc >= {1'b0, ceff}) ? 8'd0 : pend_inc[7:0];
        pend_prv = (pend_q == 8'd0) ? (ceff - 8'd1) : (pend_q - 8'd1);
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (press[0])        pend_d = 8'd0;
                else if (press[1])   pend_d = pend_nxt;
                else if (press[2])   pend_d = pend_prv;
                else if (press[3]) begin
                    work_d  = bus.load_value;
                    state_d = ST_REDUCE;
                end
                else if (auto_pulse) pend_d = pend_nxt;
                else if (pend_q >= ceff) pend_d = 8'd0;
            end
            default: begin
                if (work_q >= ceff) begin
                    work_d = work_q - ceff;
                end else begin
                    pend_d  = work_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
        // commit samples pend before any same-cycle update
        index_d   = bus.frame_start ? pend_q : index_q;
        changed_d = bus.frame_start && (pend_q != index_q);
        busy_d    = (state_d == ST_REDUCE);
    end

`ifdef AUTO_CYCLE_EN
    localparam logic [8:0] AUTO_LIM = 9'(AUTO_FRAMES);
    logic [7:0] fcnt_q, fcnt_d;
    logic       auto_q, auto_d;

    always_comb begin
        fcnt_d = fcnt_q;
        auto_d = 1'b0;
        if (!bus.auto_en || (press != 4'd0)) begin
            fcnt_d = 8'd0;
        end else if (bus.frame_start && (state_q == ST_IDLE)) begin
            if (({1'b0, fcnt_q} + 9'd1) == AUTO_LIM) begin
                fcnt_d = 8'd0;
                auto_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 8'd0;
            auto_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            auto_q <= auto_d;
        end
    end

    assign auto_pulse = auto_q;
`else
    logic unused_auto_en;
    assign unused_auto_en = bus.auto_en;
    assign auto_pulse     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_state_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            state_q    <= ST_IDLE;
            pend_q     <= 8'd0;
            work_q     <= 8'd0;
            index_q    <= 8'd0;
            changed_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_state_q <= db_state_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q    <= state_d;
            pend_q     <= pend_d;
            work_q     <= work_d;
            index_q    <= index_d;
            changed_q  <= changed_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.index         = index_q;
    assign bus.index_changed = changed_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_flag_select_ctrl.sv
// Scoreboard bench for flag_select_ctrl: modulo-arithmetic index model, commit and busy-length queues.
module tb_flag_select_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flag_select_ctrl_if bus_if ();

    flag_select_ctrl #(
        .DB_WIDTH   (8),
        .DB_LIMIT   (4),
        .AUTO_FRAMES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    typedef struct {
        int idx;
        bit chg;
    } commit_t;

    commit_t exp_commit[$];
    int      exp_busy[$];
    int      vectors     = 0;
    int      miscompares = 0;
    int      pend_m      = 0;
    int      index_m     = 0;
    int      count_m     = 0;

    // monitor: frame commits, spurious index_changed, busy run lengths
    bit      fs_prev  = 1'b0;
    int      busy_run = 0;
    commit_t mon_e;
    int      mon_len;

    always @(negedge clk) begin
        if (!rst_n) begin
            fs_prev  = 1'b0;
            busy_run = 0;
        end else begin
            if (fs_prev) begin
                if (exp_commit.size() == 0) begin
                    miscompares++;
                    $display("FAIL commit_unexpected: index=%0d with no expectation queued", bus_if.index);
                end else begin
                    mon_e = exp_commit.pop_front();
                    vectors++;
                    if (bus_if.index !== 8'(mon_e.idx) || bus_if.index_changed !== mon_e.chg) begin
                        miscompares++;
                        $display("FAIL commit: index=%0d changed=%b, required index=%0d changed=%b",
                                 bus_if.index, bus_if.index_changed, mon_e.idx, mon_e.chg);
                    end
                end
            end else if (bus_if.index_changed !== 1'b0) begin
                miscompares++;
                $display("FAIL spurious_change: index_changed=%b outside a commit, required 0", bus_if.index_changed);
            end
            if (bus_if.busy === 1'b1) begin
                busy_run++;
            end else if (busy_run > 0) begin
                if (exp_busy.size() == 0) begin
                    miscompares++;
                    $display("FAIL busy_unexpected: busy run of %0d cycles with no load expected", busy_run);
                end else begin
                    mon_len = exp_busy.pop_front();
                    vectors++;
                    if (busy_run != mon_len) begin
                        miscompares++;
                        $display("FAIL busy_len: busy high %0d cycles, required %0d", busy_run, mon_len);
                    end
                end
                busy_run = 0;
            end
            fs_prev = (bus_if.frame_start === 1'b1);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ceff_m();
        return (count_m == 0) ? 1 : count_m;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_if.busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("busy_timeout", int'(bus_if.busy), 0);
    endtask

    task automatic frame();
        commit_t e;
        e.idx = pend_m;
        e.chg = (pend_m != index_m);
        exp_commit.push_back(e);
        index_m = pend_m;
        bus_if.frame_start = 1'b1;
        tick();
        bus_if.frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic set_count(input int c);
        count_m = c;
        bus_if.count = 8'(c);
        repeat (3) tick();
        if (pend_m >= ceff_m()) pend_m = 0;
    endtask

    task automatic press(input logic [3:0] mask, input int lv);
        int c = ceff_m();
        bus_if.load_value = 8'(lv);
        if (mask[0])      pend_m = 0;
        else if (mask[1]) pend_m = (pend_m + 1) % c;
        else if (mask[2]) pend_m = (pend_m + c - 1) % c;
        else if (mask[3]) begin
            exp_busy.push_back(lv / c + 1);
            pend_m = lv % c;
        end
        {bus_if.btn_load, bus_if.btn_prev, bus_if.btn_next, bus_if.btn_reset} = mask;
        repeat (10) tick();
        {bus_if.btn_load, bus_if.btn_prev, bus_if.btn_next, bus_if.btn_reset} = 4'b0000;
        repeat (12) tick();
        wait_idle();
    endtask

    task automatic glitch();
        bus_if.btn_next = 1'b1;
        repeat (3) tick();
        bus_if.btn_next = 1'b0;
        repeat (10) tick();
    endtask

    // mode 1: frame_start while reducing; mode 2: next press while reducing
    task automatic load_busy(input int lv, input int mode);
        int n = 0;
        int c = ceff_m();
        commit_t e;
        bus_if.load_value = 8'(lv);
        exp_busy.push_back(lv / c + 1);
        bus_if.btn_load = 1'b1;
        while (bus_if.busy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("busy_start", int'(bus_if.busy), 1);
        if (mode == 1) begin
            e.idx = pend_m;
            e.chg = (pend_m != index_m);
            exp_commit.push_back(e);
            index_m = pend_m;
            bus_if.frame_start = 1'b1;
            tick();
            bus_if.frame_start = 1'b0;
        end else begin
            bus_if.btn_next = 1'b1;
        end
        repeat (12) tick();
        bus_if.btn_load = 1'b0;
        bus_if.btn_next = 1'b0;
        repeat (12) tick();
        pend_m = lv % c;
        wait_idle();
    endtask

    initial begin
        int op;
        int lv;
        int n;
        bus_if.btn_reset   = 1'b0;
        bus_if.btn_next    = 1'b0;
        bus_if.btn_prev    = 1'b0;
        bus_if.btn_load    = 1'b0;
        bus_if.load_value  = 8'd0;
        bus_if.count       = 8'd0;
        bus_if.frame_start = 1'b0;
        bus_if.auto_en     = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_index", int'(bus_if.index), 0);
        check("reset_busy", int'(bus_if.busy), 0);
        check("reset_changed", int'(bus_if.index_changed), 0);
        rst_n = 1'b1;
        tick();

        set_count(7);
        frame();
        glitch();
        frame();
        press(4'b0010, 0);
        frame();
        press(4'b0100, 0);
        press(4'b0100, 0);
        press(4'b0010, 0);
        press(4'b0100, 0);
        frame();
        set_count(5);
        frame();
        load_busy(23, 1);
        frame();
        press(4'b0011, 0);
        frame();
        set_count(2);
        load_busy(201, 2);
        frame();
        set_count(0);
        press(4'b0010, 0);
        frame();
        set_count(255);
        press(4'b0100, 0);
        press(4'b0010, 0);
        frame();

        for (int it = 0; it < 40; it++) begin
            bus_if.auto_en = 1'($urandom_range(0, 1));
            op = $urandom_range(0, 7);
            case (op)
                0: press(4'b0010, 0);
                1: press(4'b0100, 0);
                2: press(4'b0001, 0);
                3: press(4'($urandom_range(1, 15)), $urandom_range(0, 255));
                4: press(4'b1000, $urandom_range(0, 255));
                5: set_count(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12));
                6: glitch();
                default: begin
                    if (ceff_m() > 20) set_count($urandom_range(1, 20));
                    lv = $urandom_range(12 * ceff_m(), 255);
                    load_busy(lv, $urandom_range(1, 2));
                end
            endcase
            if ($urandom_range(0, 1) == 1) frame();
        end

        // asynchronous reset in the middle of a long reduction
        set_count(2);
        press(4'b0001, 0);
        press(4'b0010, 0);
        frame();
        bus_if.load_value = 8'd250;
        bus_if.btn_load = 1'b1;
        n = 0;
        while (bus_if.busy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("abort_busy_start", int'(bus_if.busy), 1);
        repeat (5) tick();
        rst_n = 1'b0;
        bus_if.btn_load = 1'b0;
        #1;
        check("abort_busy", int'(bus_if.busy), 0);
        check("abort_index", int'(bus_if.index), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        pend_m  = 0;
        index_m = 0;
        repeat (5) tick();
        frame();

        repeat (20) tick();
        check("commit_queue_drained", exp_commit.size(), 0);
        check("busy_queue_drained", exp_busy.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
